// File: rtl/board_ram_arbiter.sv
// Round-robin, lockable owner arbiter for the single-port board RAM.
// Muxes the owner's access onto the RAM, guards out-of-board cells and tags read returns.
module board_ram_arbiter #(
   parameter int unsigned     NREQ     = 4,
   parameter int unsigned     AW       = 8,
   parameter int unsigned     DW       = 6,
   parameter int unsigned     DEPTH    = 200,
   parameter int unsigned     RD_LAT   = 2,
   parameter logic [DW-1:0]   OOB_FILL = DW'(6'h3F)
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic [NREQ-1:0]      req_i,
   input  logic [NREQ*AW-1:0]   addr_i,
   input  logic [NREQ-1:0]      wren_i,
   input  logic [NREQ*DW-1:0]   wdata_i,
   output logic [NREQ-1:0]      gnt_o,
   output logic [AW-1:0]        ram_addr_o,
   output logic                 ram_wren_o,
   output logic [DW-1:0]        ram_wdata_o,
   input  logic [DW-1:0]        ram_q_i,
   output logic [DW-1:0]        rdata_o,
   output logic [NREQ-1:0]      rvalid_o
);

   localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_OWN     = 2'd1;
   localparam logic [1:0] ST_RELEASE = 2'd2;

   logic [1:0]      state_q, state_d;
   logic [NREQ-1:0] gnt_q, gnt_d;
   logic [IW-1:0]   last_q, last_d;

   logic [RD_LAT-1:0][NREQ-1:0] tag_q;
   logic [RD_LAT-1:0]           oob_q;

   logic [IW-1:0]   win;
   logic            any_req;
   logic [IW-1:0]   own;
   logic            access;
   logic [AW-1:0]   own_addr;
   logic [DW-1:0]   own_wdata;
   logic            own_wren;
   logic            in_range;
   logic [NREQ-1:0] push_tag;
   logic            push_oob;

   // Round-robin search starting just after the last winner
   always_comb begin
      logic [IW-1:0] cand;
      win     = '0;
      any_req = 1'b0;
      cand    = '0;
      for (int unsigned k = 1; k <= NREQ; k++) begin
         cand = IW'((32'(last_q) + k) % NREQ);
         if (!any_req && req_i[cand]) begin
            any_req = 1'b1;
            win     = cand;
         end
      end
   end

   always_comb begin
      own = '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         if (gnt_q[IW'(i)]) own = IW'(i);
      end
   end

   assign own_addr  = addr_i[32'(own) * AW +: AW];
   assign own_wdata = wdata_i[32'(own) * DW +: DW];
   assign own_wren  = wren_i[own];
   assign access    = |(gnt_q & req_i);
   assign in_range  = 32'(own_addr) < DEPTH;

   // Out-of-board cells never reach the RAM: address parked at 0, write suppressed
   assign ram_addr_o  = (access && in_range) ? own_addr : '0;
   assign ram_wren_o  = access & own_wren & in_range;
   assign ram_wdata_o = access ? own_wdata : '0;

   assign push_tag = (access && !own_wren) ? gnt_q : '0;
   assign push_oob = access & ~own_wren & ~in_range;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
         gnt_q   <= '0;
         last_q  <= IW'(NREQ - 1);
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         last_q  <= last_d;
      end
   end

   always_comb begin
      state_d = state_q;
      gnt_d   = gnt_q;
      last_d  = last_q;
      case (state_q)
         ST_IDLE, ST_RELEASE: begin
            if (any_req) begin
               gnt_d   = NREQ'(1) << win;
               last_d  = win;
               state_d = ST_OWN;
            end else begin
               gnt_d   = '0;
               state_d = ST_IDLE;
            end
         end
         ST_OWN: begin
            if (!req_i[own]) begin
               gnt_d   = '0;
               state_d = ST_RELEASE;
            end
         end
         default: begin
            gnt_d   = '0;
            state_d = ST_IDLE;
         end
      endcase
   end

   // Read-return pipeline: the requester tag travels alongside the RAM latency
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         tag_q <= '0;
         oob_q <= '0;
      end else begin
         tag_q[0] <= push_tag;
         oob_q[0] <= push_oob;
         for (int unsigned s = 1; s < RD_LAT; s++) begin
            tag_q[s] <= tag_q[s-1];
            oob_q[s] <= oob_q[s-1];
         end
      end
   end

   assign gnt_o    = gnt_q;
   assign rvalid_o = tag_q[RD_LAT-1];
   assign rdata_o  = (|tag_q[RD_LAT-1]) ? (oob_q[RD_LAT-1] ? OOB_FILL : ram_q_i) : '0;

endmodule
